// File: rtl/cordic_pkg.sv
// cordic_pkg: shared flop macros, arctangent table, 1/K constant and mode encoding for the CORDIC core.
`ifndef CORDIC_DFF_MACROS
`define CORDIC_DFF_MACROS
`define DFF(q, d, rv) always_ff @(posedge clk_i or negedge rst_ni) if (!rst_ni) q <= rv; else q <= d;
`define DFFE(q, d, e, rv) always_ff @(posedge clk_i or negedge rst_ni) if (!rst_ni) q <= rv; else if (e) q <= d;
`endif

package cordic_pkg;

    typedef enum logic {
        MODE_VECTOR = 1'b0,
        MODE_ROTATE = 1'b1
    } mode_e;

    // atan(2^-k) as binary angles where 2^31 = pi; narrower cores keep the MSBs
    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    localparam logic [63:0] INV_K_64 = 64'h9B74_EDA8_435E_5A68;

    function automatic logic [63:0] inv_k(input int qf);
        logic [64:0] r;
        r = {1'b0, INV_K_64} + (65'd1 << (63 - qf));
        return 64'(r >> (64 - qf));
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one combinational CORDIC micro-rotation by atan(2^-SHIFT).
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int XW    = 34,
    parameter int WIDTH = 32,
    parameter int SHIFT = 0
) (
    input  logic                    mode,
    input  logic signed [XW-1:0]    x,
    input  logic signed [XW-1:0]    y,
    input  logic signed [WIDTH-1:0] z,
    output logic signed [XW-1:0]    x_n,
    output logic signed [XW-1:0]    y_n,
    output logic signed [WIDTH-1:0] z_n
);
    localparam logic signed [WIDTH-1:0] ATAN = ATAN_TABLE[SHIFT][31 -: WIDTH];

    logic pos;
    logic signed [XW-1:0] xs, ys;

    assign pos = (mode_e'(mode) == MODE_ROTATE) ? ~z[WIDTH-1] : y[XW-1];
    assign xs  = x >>> SHIFT;
    assign ys  = y >>> SHIFT;
    assign x_n = pos ? x - ys : x + ys;
    assign y_n = pos ? y + xs : y - xs;
    assign z_n = pos ? z - ATAN : z + ATAN;

endmodule

// File: rtl/cordic_core.sv
// cordic_core: pipelined CORDIC (vectoring/rotation) with quadrant pre-rotation,
// gain compensation and a single ready/valid enable across all stages.
module cordic_core
    import cordic_pkg::*;
#(
    parameter int Q_I    = 15,
    parameter int Q_F    = 16,
    parameter int WIDTH  = Q_I + Q_F + 1,
    parameter int STAGES = WIDTH / 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    mode_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] z_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic signed [WIDTH-1:0] x_o,
    output logic signed [WIDTH-1:0] y_o,
    output logic signed [WIDTH-1:0] z_o,
    output logic                    mode_o
);
    if (WIDTH != Q_I + Q_F + 1 || WIDTH < 8 || WIDTH > 32) begin : g_bad_width
        $error("cordic_core: WIDTH must equal Q_I+Q_F+1 and lie in 8..32");
    end
    if (STAGES < 1 || STAGES > WIDTH - 2) begin : g_bad_stages
        $error("cordic_core: STAGES must lie in 1..WIDTH-2");
    end

    localparam int XW = WIDTH + 2;
    localparam int PW = XW + Q_F + 2;
    localparam logic signed [WIDTH-1:0] QTR = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [Q_F+1:0] INV_K = (Q_F+2)'(inv_k(Q_F));

    function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> Q_F;
        return (&s[PW-1:WIDTH-1] || ~|s[PW-1:WIDTH-1]) ? s[WIDTH-1:0] : {s[PW-1], {(WIDTH-1){~s[PW-1]}}};
    endfunction

    logic                    en, flip;
    logic [STAGES:0]         vr, vn, mr, mn;
    logic signed [XW-1:0]    xr [STAGES+1];
    logic signed [XW-1:0]    yr [STAGES+1];
    logic signed [XW-1:0]    xn [STAGES+1];
    logic signed [XW-1:0]    yn [STAGES+1];
    logic signed [WIDTH-1:0] zr [STAGES+1];
    logic signed [WIDTH-1:0] zn [STAGES+1];
    logic signed [PW-1:0]    px, py;

    assign en      = ready_i | ~valid_o;
    assign ready_o = en;

    // Fold the input into the right half-plane (vectoring) or |z| <= pi/2 (rotation)
    assign flip  = (mode_e'(mode_i) == MODE_ROTATE) ? (z_i > QTR || z_i < -QTR) : x_i[WIDTH-1];
    assign xn[0] = flip ? -XW'(x_i) : XW'(x_i);
    assign yn[0] = flip ? -XW'(y_i) : XW'(y_i);
    assign zn[0] = flip ? (z_i ^ HALF) : z_i;
    assign vn    = {vr[STAGES-1:0], valid_i};
    assign mn    = {mr[STAGES-1:0], mode_i};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cordic_stage #(.XW(XW), .WIDTH(WIDTH), .SHIFT(k)) u_stage (
            .mode (mr[k]),
            .x    (xr[k]),
            .y    (yr[k]),
            .z    (zr[k]),
            .x_n  (xn[k+1]),
            .y_n  (yn[k+1]),
            .z_n  (zn[k+1])
        );
    end

    `DFFE(xr, xn, en, '{default: '0})
    `DFFE(yr, yn, en, '{default: '0})
    `DFFE(zr, zn, en, '{default: '0})
    `DFFE(vr, vn, en, '0)
    `DFFE(mr, mn, en, '0)

    assign px = PW'(xr[STAGES]) * PW'(INV_K);
    assign py = PW'(yr[STAGES]) * PW'(INV_K);

    `DFFE(x_o, sat(px), en, '0)
    `DFFE(y_o, sat(py), en, '0)
    `DFFE(z_o, zr[STAGES], en, '0)
    `DFFE(mode_o, mr[STAGES], en, 1'b0)
    `DFFE(valid_o, vr[STAGES], en, 1'b0)

endmodule

// File: doc/cordic_core.md
CORDIC_CORE -- requirements
Module: cordic_core

Interface
REQ-001 SHALL have parameter Q_I, default 15, integer bits of x/y data.
REQ-002 SHALL have parameter Q_F, default 16, fractional bits of x/y data.
REQ-003 SHALL have parameter WIDTH, default Q_I+Q_F+1, total data/angle width; a static assertion SHALL enforce WIDTH == Q_I+Q_F+1 and 8 <= WIDTH <= 32.
REQ-004 SHALL have parameter STAGES, default WIDTH/2, iteration count; a static assertion SHALL enforce 1 <= STAGES <= WIDTH-2.
REQ-005 One clock; reset is asynchronous and active-low. Ports: clk_i, rst_ni.
REQ-006 clk_i  in  1  rising-edge clock.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 valid_i  in  1  input sample valid.
REQ-009 ready_o  out  1  block can accept input this cycle.
REQ-010 mode_i  in  1  0 = vectoring, 1 = rotation.
REQ-011 x_i, y_i  in  WIDTH each  signed Q_I.Q_F vector.
REQ-012 z_i  in  WIDTH  signed binary angle, 2^(WIDTH-1) LSB = pi rad.
REQ-013 valid_o  out  1  output valid.
REQ-014 ready_i  in  1  downstream accepts output.
REQ-015 x_o, y_o  out  WIDTH each  signed Q_I.Q_F, gain-compensated.
REQ-016 z_o  out  WIDTH  binary angle; mode_o  out  1  mode of this sample.

Function
REQ-017 Transfer SHALL occur on valid&ready at each port; en = ready_i | ~valid_o; ready_o = en (combinational path from ready_i is permitted).
REQ-018 All pipeline registers (data, mode, valid) SHALL advance only when en=1 and hold otherwise; data registers load regardless of valid (no per-stage gating needed).
REQ-019 Latency SHALL be STAGES+2 enabled cycles: input/pre-rotation register, STAGES iteration registers, gain register; throughput one sample per cycle when ready_i=1.
REQ-020 Bubbles SHALL travel with the pipeline (no collapse); samples SHALL leave in input order with no loss or duplication.
REQ-021 Internal x/y width SHALL be WIDTH+2 (sign-extended) to absorb CORDIC gain and pre-rotation growth; z SHALL be WIDTH and wrap modulo 2*pi.
REQ-022 Pre-rotation: vectoring with x_i<0, or rotation with |z_i| > pi/2, SHALL negate x and y and add 2^(WIDTH-1) to z (wrapping).
REQ-023 Iteration k (0..STAGES-1): d=+1 if (rotation: z>=0) or (vectoring: y<0), else -1; x'=x-d*(y>>>k), y'=y+d*(x>>>k), z'=z-d*atan_k.
REQ-024 Vectoring result: x_o=|(x_i,y_i)|, y_o~0, z_o=z_i+atan2(y_i,x_i); rotation result: (x_o,y_o) = input rotated by z_i, z_o~0.
REQ-025 Gain stage SHALL multiply x and y by 1/K (K=1.6467602581, rounded to Q_F bits), arithmetic-shift right by Q_F (truncate), saturate to signed WIDTH range.
REQ-026 mode SHALL be pipelined alongside data and select per-stage d rule, so modes may change every sample.
REQ-027 Accuracy with defaults: |error| <= 2^-12 on x/y (relative to 1.0) and <= 2^(WIDTH-13) LSB on z for non-saturating inputs.

Reset
REQ-028 Reset SHALL clear all valid registers, mode registers and data registers to 0; outputs valid_o=0, x_o=y_o=z_o=0, mode_o=0, ready_o=1.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight samples; first output after release SHALL originate from an input accepted after release.

Structure
REQ-030 Package cordic_pkg SHALL hold: 32-entry atan table (32-bit binary angles, sliced to WIDTH MSBs), 1/K constant (64-bit, sliced), mode_e enum (MODE_VECTOR=0, MODE_ROTATE=1).
REQ-031 One sub-module cordic_stage (parameter SHIFT, combinational single iteration) SHALL be instantiated STAGES times via generate; flops SHALL use the shared DFF/DFFE macros.

Verification
REQ-032 Vectoring x=3.0 (0x0003_0000), y=4.0, z=0 -> x_o=5.0 (0x0005_0000) ±2^-12, z_o=0.2952*2^31 ±2^19 LSB, after exactly STAGES+2 cycles.
REQ-033 Rotation x=1.0, y=0, z=0x2000_0000 (pi/4) -> x_o=y_o=0x0000_B505 ±16 LSB.
REQ-034 Vectoring x=-2.0, y=0 -> x_o=2.0, y_o~0, z_o=0x8000_0000 ±2^19 LSB.
REQ-035 Stream 20 alternating-mode random samples back-to-back, ready_i low 3 cycles mid-stream -> all 20 outputs match model, in order, outputs stable while stalled.
REQ-036 Assert rst_ni for 1 cycle with 5 samples in flight -> valid_o low next cycle, none of the 5 ever emitted; new input after release returns in STAGES+2 cycles.
REQ-037 Sweep STAGES in {4, 16} and WIDTH in {16, 32} with REQ-032 stimulus scaled -> error bound scales as 2^-STAGES.
